// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcodes, ALU class codes, mux selects and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU operand B selects: register B, constant 4, sign-extended imm, imm << 2
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source selects: ALU result, ALUOut (branch target), jump address
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-controls decoder. Outputs depend on the state only,
// except that the FETCH write strobes and the MEM_WR completion pulse are
// qualified by the effective memory-ready, and illegal_op by the opcode check.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_rdy,
    input  logic   i_op_legal,
    output ctrl_t  o_ctrl
);

    // Decode the current state into the datapath control word
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = i_mem_rdy;
                o_ctrl.pc_write  = i_mem_rdy;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMM_SH;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.illegal_op = ~i_op_legal;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.i_or_d     = 1'b1;
                o_ctrl.instr_done = i_mem_rdy;
            end
            ST_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
            ST_ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_ADDI_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: holds the state register and next-state logic;
// control outputs come from the mips_ctrl_decode sub-module.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk_CPU,
    input  logic       rst_CPU_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_rdy;
    logic   w_op_legal;
    ctrl_t  w_ctrl;

    // Without a handshake every memory access is taken to complete at once
    assign w_mem_rdy  = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_op_legal = op_is_legal(opcode);

    // State register; reset returns to IDLE immediately so no partial instruction resumes
    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; opcode is only looked at in DECODE and MEM_ADDR
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:      w_next_state = ST_FETCH;
            ST_FETCH:     w_next_state = w_mem_rdy ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = ST_MEM_ADDR;
                    OP_RTYPE:     w_next_state = ST_R_EXEC;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
                    OP_ADDI:      w_next_state = ST_ADDI_EXEC;
                    default:      w_next_state = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  w_next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:    w_next_state = w_mem_rdy ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:    w_next_state = ST_FETCH;
            ST_MEM_WR:    w_next_state = w_mem_rdy ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:    w_next_state = ST_R_WB;
            ST_R_WB:      w_next_state = ST_FETCH;
            ST_BRANCH:    w_next_state = ST_FETCH;
            ST_JUMP:      w_next_state = ST_FETCH;
            ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
            ST_ADDI_WB:   w_next_state = ST_FETCH;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    mips_ctrl_decode u_decode (
        .i_state    (r_state),
        .i_mem_rdy  (w_mem_rdy),
        .i_op_legal (w_op_legal),
        .o_ctrl     (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign instr_done    = w_ctrl.instr_done;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed vector table,
// hand-written multi-cycle sequences and randomized run against an
// instruction-path reference model.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    logic [5:0] opcode_b;
    logic       mem_ready_b;
    logic       pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
    logic       mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, instr_done_b, illegal_op_b;
    logic [1:0] alu_src_b_b, alu_op_b, pc_source_b;
    logic [3:0] state_b;

    mips_multicycle_control dut (
        .clk_CPU(clk), .rst_CPU_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    mips_multicycle_control #(.MEM_HANDSHAKE(0)) dut_nh (
        .clk_CPU(clk), .rst_CPU_n(rst_n), .opcode(opcode_b), .mem_ready(mem_ready_b),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .i_or_d(i_or_d_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .pc_source(pc_source_b), .state(state_b), .instr_done(instr_done_b),
        .illegal_op(illegal_op_b)
    );

    logic [17:0] act_vec, act_vec_b;
    logic [7:0]  act_key;
    assign act_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, instr_done, illegal_op};
    assign act_vec_b = {pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b,
                        ir_write_b, mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b,
                        alu_src_b_b, alu_op_b, pc_source_b, instr_done_b, illegal_op_b};
    assign act_key = {mem_read, mem_write, reg_write, pc_write, pc_write_cond,
                      instr_done, illegal_op, reg_dst};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    endfunction

    // Expected control word per state, from the table of per-state controls
    function automatic logic [17:0] exp_vec(input int st, input logic rdy, input logic [5:0] op);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn, ill;
        logic [1:0] sb, ao, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mr = 1; irw = rdy; pw = rdy; sb = 2'b01; end
            2:  begin sb = 2'b11; ill = !legal(op); end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin mw = 1; iod = 1; dn = rdy; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
            10: begin pw = 1; ps = 2'b10; dn = 1; end
            11: begin sa = 1; sb = 2'b10; end
            12: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, dn, ill};
    endfunction

    // Reference model: current state plus the remaining state path of the instruction
    int m_state;
    int m_path[$];

    task automatic model_reset();
        m_state = 0;
        m_path.delete();
    endtask

    task automatic next_in_path();
        if (m_path.size() > 0) m_state = m_path.pop_front();
        else m_state = 1;
    endtask

    task automatic model_adv(input logic [5:0] op, input logic rdy);
        case (m_state)
            0: m_state = 1;
            1: if (rdy) m_state = 2;
            2: begin
                m_path.delete();
                if (op == T_LW) begin m_path.push_back(3); m_path.push_back(4); m_path.push_back(5); end
                else if (op == T_SW) begin m_path.push_back(3); m_path.push_back(6); end
                else if (op == T_R) begin m_path.push_back(7); m_path.push_back(8); end
                else if (op == T_BEQ) m_path.push_back(9);
                else if (op == T_J) m_path.push_back(10);
                else if (op == T_ADDI) begin m_path.push_back(11); m_path.push_back(12); end
                next_in_path();
            end
            4, 6: if (rdy) next_in_path();
            default: next_in_path();
        endcase
    endtask

    int prev_st, lat, lat_done;
    int rd_cnt, m2r_seen, ill_cnt, wr_cnt, bad_mw, bad_pwc, bad_jmp;
    logic seen_done;

    // One cycle: drive at negedge, check 1ns later, advance model, wait next negedge
    task automatic step(input logic [5:0] op, input logic rdy);
        opcode = op;
        mem_ready = rdy;
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("ctrl", 32'(act_vec), 32'(exp_vec(m_state, rdy, op)));
        if (state == 4'd1 && prev_st != 1) lat = 1; else lat++;
        seen_done = instr_done;
        if (instr_done) lat_done = lat;
        if (state == 4'd4 && mem_read && i_or_d) rd_cnt++;
        if (state == 4'd5 && mem_to_reg) m2r_seen++;
        if (illegal_op) ill_cnt++;
        if (reg_write || mem_write) wr_cnt++;
        if (mem_write && state != 4'd6) bad_mw++;
        if (pc_write_cond && state != 4'd9) bad_pwc++;
        if (state == 4'd10 && !(pc_write && pc_source == 2'b10)) bad_jmp++;
        prev_st = int'(state);
        model_adv(op, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prev_st = 0;
    endtask

    task automatic run_instr(input logic [5:0] op, input int exp_lat, input string name);
        lat_done = -1;
        for (int k = 0; k < 20; k++) begin
            step(op, 1'b1);
            if (seen_done) break;
        end
        chk(name, 32'(lat_done), 32'(exp_lat));
    endtask

    typedef struct packed {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [7:0] key;   // {mem_read, mem_write, reg_write, pc_write, pc_write_cond, instr_done, illegal_op, reg_dst}
    } vec_t;

    vec_t tbl[21];
    int   exp_b[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, held_op;
        logic       rdy;
        int         s;

        tbl[0]  = '{T_R,   1'b1, 4'd0,  8'b00000000};
        tbl[1]  = '{T_R,   1'b1, 4'd1,  8'b10010000};
        tbl[2]  = '{T_R,   1'b1, 4'd2,  8'b00000000};
        tbl[3]  = '{T_R,   1'b1, 4'd7,  8'b00000000};
        tbl[4]  = '{T_R,   1'b1, 4'd8,  8'b00100101};
        tbl[5]  = '{T_SW,  1'b1, 4'd1,  8'b10010000};
        tbl[6]  = '{T_SW,  1'b1, 4'd2,  8'b00000000};
        tbl[7]  = '{T_SW,  1'b1, 4'd3,  8'b00000000};
        tbl[8]  = '{T_SW,  1'b1, 4'd6,  8'b01000100};
        tbl[9]  = '{T_BEQ, 1'b1, 4'd1,  8'b10010000};
        tbl[10] = '{T_BEQ, 1'b1, 4'd2,  8'b00000000};
        tbl[11] = '{T_BEQ, 1'b1, 4'd9,  8'b00001100};
        tbl[12] = '{T_J,   1'b1, 4'd1,  8'b10010000};
        tbl[13] = '{T_J,   1'b1, 4'd2,  8'b00000000};
        tbl[14] = '{T_J,   1'b1, 4'd10, 8'b00010100};
        tbl[15] = '{T_BAD, 1'b1, 4'd1,  8'b10010000};
        tbl[16] = '{T_BAD, 1'b1, 4'd2,  8'b00000010};
        tbl[17] = '{T_BAD, 1'b0, 4'd1,  8'b10000000};
        tbl[18] = '{T_R,   1'b0, 4'd1,  8'b10000000};
        tbl[19] = '{T_R,   1'b1, 4'd1,  8'b10010000};
        tbl[20] = '{T_R,   1'b1, 4'd2,  8'b00000000};
        exp_b[0] = 0; exp_b[1] = 1; exp_b[2] = 2; exp_b[3] = 3;
        exp_b[4] = 4; exp_b[5] = 5; exp_b[6] = 1;

        rst_n = 1'b0; opcode = T_R; mem_ready = 1'b0;
        opcode_b = T_LW; mem_ready_b = 1'b0;
        prev_st = 0; lat = 0; lat_done = -1; seen_done = 1'b0;
        held_op = T_R;
        model_reset();

        // Reset state while reset is held
        @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ctrl", 32'(act_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: R-type, sw, beq, j, illegal, FETCH stall
        for (int i = 0; i < 21; i++) begin
            opcode = tbl[i].op;
            mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_key", i), 32'(act_key), 32'(tbl[i].key));
            @(negedge clk);
        end

        // Back-to-back instruction latencies with mem_ready tied high
        do_reset();
        bad_mw = 0; bad_pwc = 0; bad_jmp = 0;
        run_instr(T_SW, 4, "lat_sw");
        run_instr(T_BEQ, 3, "lat_beq");
        run_instr(T_J, 3, "lat_j");
        run_instr(T_R, 4, "lat_r");
        run_instr(T_LW, 5, "lat_lw");
        run_instr(T_ADDI, 4, "lat_addi");
        chk("mem_write_outside_s6", 32'(bad_mw), 32'd0);
        chk("pc_write_cond_outside_s9", 32'(bad_pwc), 32'd0);
        chk("jump_controls", 32'(bad_jmp), 32'd0);

        // lw with three not-ready cycles in MEM_RD
        do_reset();
        rd_cnt = 0; m2r_seen = 0; lat_done = -1;
        for (int k = 0; k < 4; k++) step(T_LW, 1'b1);
        for (int k = 0; k < 3; k++) step(T_LW, 1'b0);
        step(T_LW, 1'b1);
        step(T_LW, 1'b1);
        chk("lw_memrd_cycles", 32'(rd_cnt), 32'd4);
        chk("lw_mem_to_reg", 32'(m2r_seen), 32'd1);
        chk("lw_stalled_latency", 32'(lat_done), 32'd8);

        // Illegal opcode: one pulse, back to FETCH, no writes
        do_reset();
        ill_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < 4; k++) step(T_BAD, 1'b1);
        chk("illegal_pulses", 32'(ill_cnt), 32'd1);
        chk("illegal_writes", 32'(wr_cnt), 32'd0);

        // Asynchronous reset in the middle of a held MEM_WR
        do_reset();
        for (int k = 0; k < 4; k++) step(T_SW, 1'b1);
        step(T_SW, 1'b0);
        opcode = T_SW; mem_ready = 1'b0;
        #1;
        chk("memwr_held_state", 32'(state), 32'd6);
        chk("memwr_held_mw", 32'(mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_mw", 32'(mem_write), 32'd0);
        chk("async_rst_ctrl", 32'(act_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prev_st = 0;
        step(T_SW, 1'b1);
        step(T_SW, 1'b1);

        // Randomized run against the reference model, with occasional async resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                opcode = 6'($urandom);
                #3;
                rst_n = 1'b0;
                #1;
                chk("rand_rst_state", 32'(state), 32'd0);
                chk("rand_rst_ctrl", 32'(act_vec), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                prev_st = 0;
            end else begin
                s = m_state;
                case ($urandom_range(0, 7))
                    0: op = T_R;
                    1: op = T_LW;
                    2: op = T_SW;
                    3: op = T_BEQ;
                    4: op = T_J;
                    5: op = T_ADDI;
                    default: op = 6'($urandom);
                endcase
                if (s == 3) op = held_op;
                if (s == 2) held_op = op;
                rdy = ($urandom_range(0, 3) != 0);
                step(op, rdy);
            end
        end

        // No-handshake instance: lw completes in 5 cycles with mem_ready held low
        do_reset();
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("nh_state%0d", k), 32'(state_b), 32'(exp_b[k]));
            chk($sformatf("nh_ctrl%0d", k), 32'(act_vec_b), 32'(exp_vec(exp_b[k], 1'b1, T_LW)));
            chk($sformatf("nh_done%0d", k), 32'(instr_done_b), (k == 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1; 1 = memory states wait for mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 clk_CPU  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_CPU_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction register bits [31:26].
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-007 alu_src_b, alu_op, pc_source  output  2 each  datapath mux and ALU-class selects.
REQ-008 state  output  4  current state encoding, for debug.
REQ-009 instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-010 illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-011 States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12; codes 13-15 are unused and go to IDLE on the next edge.
REQ-012 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-013 IDLE goes to FETCH unconditionally on the next edge; every output is 0 in IDLE.
REQ-014 FETCH drives mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-015 FETCH holds while mem_ready=0; ir_write and pc_write are asserted only in the cycle where mem_ready=1, and the FSM then goes to DECODE.
REQ-016 DECODE drives alu_src_a=0, alu_src_b=11, alu_op=00 to compute the branch target.
REQ-017 DECODE transitions: lw/sw go to MEM_ADDR; R-type goes to R_EXEC; beq goes to BRANCH; j goes to JUMP; addi goes to ADDI_EXEC; any other opcode asserts illegal_op and goes to FETCH with no register or memory write.
REQ-018 MEM_ADDR drives alu_src_a=1, alu_src_b=10, alu_op=00, then goes to MEM_RD for lw or MEM_WR for sw.
REQ-019 MEM_RD drives mem_read=1, i_or_d=1, holds until mem_ready=1, then goes to MEM_WB.
REQ-020 MEM_WB drives reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-021 MEM_WR drives mem_write=1, i_or_d=1; mem_write stays high while held; the FSM holds until mem_ready=1.
REQ-022 R_EXEC drives alu_src_a=1, alu_src_b=00, alu_op=10; R_WB drives reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-023 BRANCH drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-024 JUMP drives pc_write=1, pc_source=10.
REQ-025 ADDI_EXEC drives alu_src_a=1, alu_src_b=10, alu_op=00; ADDI_WB drives reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-026 MEM_WB, MEM_WR (completing cycle), R_WB, BRANCH, JUMP and ADDI_WB assert instr_done and return to FETCH.
REQ-027 Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles (FETCH to instr_done inclusive).
REQ-028 Outputs are Moore, decoded from state only, except the mem_ready qualification in REQ-015.
REQ-029 Any control not listed for a state is 0 in that state.
REQ-030 opcode is sampled only in DECODE and MEM_ADDR; changes in other states have no effect.

Reset
REQ-031 rst_CPU_n=0 forces state to IDLE immediately, including mid-instruction or mid-wait, and all outputs go to 0 without waiting for a clock edge.
REQ-032 After rst_CPU_n rises, the first edge moves IDLE to FETCH; no partial instruction resumes.

Structure
REQ-033 Shared package mips_ctrl_pkg holds the state codes, the opcode constants and the alu_op codes (00 add, 01 sub, 10 funct).
REQ-034 One sub-module, mips_ctrl_decode, is the purely combinational state-to-controls decoder; the top module holds the state register and the next-state logic.

Verification
REQ-035 Reset, then opcode=000000 with mem_ready=1 -> states 0,1,2,7,8,1; reg_write=1 and reg_dst=1 in state 8; instr_done on cycle 4.
REQ-036 lw (100011) with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1 and i_or_d=1; MEM_WB then has mem_to_reg=1.
REQ-037 sw, then beq, then j back-to-back -> mem_write only in state 6, pc_write_cond only in state 9, pc_write+pc_source=10 in state 10; latencies 4, 3, 3.
REQ-038 opcode=111111 -> illegal_op pulses once in DECODE, next state FETCH, reg_write and mem_write never asserted.
REQ-039 Assert rst_CPU_n=0 mid-MEM_WR, between clock edges -> state=0 and mem_write=0 within the same cycle; after release, FETCH follows on the first edge.
REQ-040 MEM_HANDSHAKE=0 with mem_ready held 0 -> lw completes in 5 cycles.
